// File: rtl/alu_pkg.sv
// Shared ALU function-select and flag encodings plus the multiply sequencer state type.
// The NEG1/NEG2 states exist only when MUL_SIGNED_EN is defined.
package alu_pkg;

    localparam logic [4:0] ALU_PASS_A = 5'h10;
    localparam logic [4:0] ALU_PASS_B = 5'h11;
    localparam logic [4:0] ALU_NOT_A  = 5'h12;
    localparam logic [4:0] ALU_ADD    = 5'h14;
    localparam logic [4:0] ALU_LSR    = 5'h1C;

    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_O = 0;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_ADD  = 3'd2,
        S_DBL  = 3'd3,
        S_SHR  = 3'd4,
        S_DONE = 3'd5
`ifdef MUL_SIGNED_EN
        ,
        S_NEG1 = 3'd6,
        S_NEG2 = 3'd7
`endif
    } mul_state_e;

endpackage

// File: rtl/alu_mul_sequencer_if.sv
// Operand/function bus between the multiply sequencer (master) and the shared ALU (slave).
interface alu_mul_sequencer_if;

    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  alu_fun_sel;
    logic        alu_wf;
    logic [31:0] alu_out;
    logic [3:0]  alu_flags;

    modport master (
        output alu_a,
        output alu_b,
        output alu_fun_sel,
        output alu_wf,
        input  alu_out,
        input  alu_flags
    );

    modport slave (
        input  alu_a,
        input  alu_b,
        input  alu_fun_sel,
        input  alu_wf,
        output alu_out,
        output alu_flags
    );

endinterface

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add multiplier that runs every add, double and shift through the shared ALU.
// Define MUL_SIGNED_EN to add two's-complement operation (sign-magnitude plus final negate).
module alu_mul_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic                i_signed,
    input  logic [WIDTH-1:0]    i_multiplicand,
    input  logic [WIDTH-1:0]    i_multiplier,
    output logic                o_busy,
    output logic                o_done,
    output logic [31:0]         o_product,
    alu_mul_sequencer_if.master alu
);

    mul_state_e  r_state;
    mul_state_e  w_state_nxt;
    mul_state_e  w_exit_state;

    logic [31:0] r_acc;
    logic [31:0] r_mcand;
    logic [31:0] r_mplier;
    logic        r_neg;
    logic [31:0] r_product;

    logic [31:0] w_mcand_init;
    logic [31:0] w_mplier_init;
    logic        w_neg_init;
    logic        w_unused;

`ifdef MUL_SIGNED_EN
    function automatic logic [31:0] magnitude(input logic [WIDTH-1:0] v, input logic as_signed);
        logic [WIDTH-1:0] m;
        m = (as_signed && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
        return {{(32-WIDTH){1'b0}}, m};
    endfunction

    assign w_mcand_init  = magnitude(i_multiplicand, i_signed);
    assign w_mplier_init = magnitude(i_multiplier, i_signed);
    assign w_neg_init    = i_signed & (i_multiplicand[WIDTH-1] ^ i_multiplier[WIDTH-1]);
`else
    assign w_mcand_init  = {{(32-WIDTH){1'b0}}, i_multiplicand};
    assign w_mplier_init = {{(32-WIDTH){1'b0}}, i_multiplier};
    assign w_neg_init    = 1'b0;
`endif

    // Carry and overflow never matter for an in-range product; Signed is inert when unsigned-only.
    assign w_unused = ^{i_signed, r_neg, alu.alu_flags[FLAG_C], alu.alu_flags[FLAG_N],
                        alu.alu_flags[FLAG_O]};

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Z was latched by the ALU on the falling edge of this same cycle, so it describes alu_out now.
    always_comb begin
        if (alu.alu_flags[FLAG_Z]) begin
`ifdef MUL_SIGNED_EN
            w_exit_state = r_neg ? S_NEG1 : S_DONE;
`else
            w_exit_state = S_DONE;
`endif
        end else if (alu.alu_out[0]) begin
            w_exit_state = S_ADD;
        end else begin
            w_exit_state = S_DBL;
        end
    end

    // NOTE: every output gets its idle value first, so no branch can infer a latch.
    always_comb begin
        w_state_nxt     = r_state;
        alu.alu_a       = 32'd0;
        alu.alu_b       = 32'd0;
        alu.alu_fun_sel = ALU_PASS_A;
        alu.alu_wf      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                // Multiplier was captured at Start so the operand need not stay on the pins.
                alu.alu_b       = r_mplier;
                alu.alu_fun_sel = ALU_PASS_B;
                alu.alu_wf      = 1'b1;
                w_state_nxt     = w_exit_state;
            end
            S_ADD: begin
                alu.alu_a       = r_acc;
                alu.alu_b       = r_mcand;
                alu.alu_fun_sel = ALU_ADD;
                w_state_nxt     = S_DBL;
            end
            S_DBL: begin
                alu.alu_a       = r_mcand;
                alu.alu_b       = r_mcand;
                alu.alu_fun_sel = ALU_ADD;
                w_state_nxt     = S_SHR;
            end
            S_SHR: begin
                alu.alu_a       = r_mplier;
                alu.alu_fun_sel = ALU_LSR;
                alu.alu_wf      = 1'b1;
                w_state_nxt     = w_exit_state;
            end
`ifdef MUL_SIGNED_EN
            S_NEG1: begin
                alu.alu_a       = r_acc;
                alu.alu_fun_sel = ALU_NOT_A;
                w_state_nxt     = S_NEG2;
            end
            S_NEG2: begin
                alu.alu_a       = r_acc;
                alu.alu_b       = 32'd1;
                alu.alu_fun_sel = ALU_ADD;
                w_state_nxt     = S_DONE;
            end
`endif
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc     <= 32'd0;
            r_mcand   <= 32'd0;
            r_mplier  <= 32'd0;
            r_neg     <= 1'b0;
            r_product <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_acc    <= 32'd0;
                        r_mcand  <= w_mcand_init;
                        r_mplier <= w_mplier_init;
                        r_neg    <= w_neg_init;
                    end
                end
                S_LOAD, S_SHR: r_mplier <= alu.alu_out;
                S_ADD:         r_acc    <= alu.alu_out;
                S_DBL:         r_mcand  <= alu.alu_out;
`ifdef MUL_SIGNED_EN
                S_NEG1, S_NEG2: r_acc   <= alu.alu_out;
`endif
                S_DONE:        r_product <= r_acc;
                default: ;
            endcase
        end
    end

    assign o_busy    = (r_state != S_IDLE) && (r_state != S_DONE);
    assign o_done    = (r_state == S_DONE);
    assign o_product = r_product;

endmodule
